// File: rtl/reg_load_arbiter_pkg.sv
// Shared definitions for the register-file load arbiter.
//   - arb_state_e : two-state arbiter FSM encoding (ARB / WRITE)
//   - DEFAULT_DATA_W / DEFAULT_ADDR_W : default bus and register-select widths
//   - onehot()    : index-to-one-hot decode, used for both GNT and LOAD
package reg_load_arbiter_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    WRITE = 1'b1
  } arb_state_e;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 3;

  // Widest vector onehot() can produce; callers truncate to their own width.
  localparam int ONEHOT_MAX_W = 32;

  // Decode an index into a one-hot vector; out-of-range indices give all zero.
  function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int unsigned idx);
    logic [ONEHOT_MAX_W-1:0] vec;
    vec = '0;
    if (idx < 32'(ONEHOT_MAX_W)) begin
      vec[idx] = 1'b1;
    end else begin
      vec = '0;
    end
    return vec;
  endfunction

endpackage

// File: rtl/reg_load_arbiter_rr_priority_pick.sv
// Combinational round-robin picker.
//   req_i    : request vector, one bit per requester
//   ptr_i    : index of the currently highest-priority requester
//   winner_o : first requester with req set, scanning upward from ptr_i and
//              wrapping modulo NUM_REQ
//   valid_o  : high when any request is set (winner_o is meaningful)
// Kept free of arbiter state so it can be reused by other port arbiters.
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               valid_o
);

  // Scan offsets from farthest to nearest so the nearest set request, i.e.
  // the highest-priority one, is the last to overwrite the result.
  always_comb begin
    int idx_s;
    winner_o = '0;
    valid_o  = 1'b0;
    idx_s    = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx_s = (int'(ptr_i) + off) % NUM_REQ;
      if (req_i[idx_s]) begin
        winner_o = IDX_W'(idx_s);
        valid_o  = 1'b1;
      end else begin
        winner_o = winner_o;
        valid_o  = valid_o;
      end
    end
  end

endmodule

// File: rtl/reg_load_arbiter.sv
// Register-file write-path arbiter.
// Picks one pending requester per arbitration by round-robin, then for one
// cycle drives the shared data bus, a single register LOAD strobe and a GNT
// pulse back to the winner. All outputs are registered.
//   CLOCK    : system clock, rising edge
//   RESET    : synchronous active-high reset
//   REQ      : per-requester write request (level)
//   REQ_ADDR : per-requester target register, slice [i*ADDR_W +: ADDR_W]
//   REQ_DATA : per-requester write data, slice [i*DATA_W +: DATA_W]
//   GNT      : one-hot one-cycle grant pulse
//   LOAD     : one-hot register load strobe
//   BUS_DATA : shared data bus feeding every register
//   ERR      : one-cycle pulse when the granted address is >= NUM_REGS
//   BUSY     : high during the WRITE cycle
module reg_load_arbiter
  import reg_load_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int DATA_W   = DEFAULT_DATA_W
) (
  input  logic                      CLOCK,
  input  logic                      RESET,
  input  logic [NUM_REQ-1:0]        REQ,
  input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
  input  logic [NUM_REQ*DATA_W-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]        GNT,
  output logic [NUM_REGS-1:0]       LOAD,
  output logic [DATA_W-1:0]         BUS_DATA,
  output logic                      ERR,
  output logic                      BUSY
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q,   ptr_d;
  logic [NUM_REQ-1:0]  gnt_q,   gnt_d;
  logic [NUM_REGS-1:0] load_q,  load_d;
  logic [DATA_W-1:0]   bus_q,   bus_d;
  logic                err_q,   err_d;
  logic                busy_q,  busy_d;

  logic [IDX_W-1:0]    pick_idx_s;
  logic                pick_vld_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_data_s;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i    (REQ),
    .ptr_i    (ptr_q),
    .winner_o (pick_idx_s),
    .valid_o  (pick_vld_s)
  );

  assign sel_addr_s = REQ_ADDR[pick_idx_s*ADDR_W +: ADDR_W];
  assign sel_data_s = REQ_DATA[pick_idx_s*DATA_W +: DATA_W];

  // Next-state and next-output logic for the ARB/WRITE FSM.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    load_d  = '0;
    bus_d   = bus_q;
    err_d   = 1'b0;
    busy_d  = 1'b0;
    case (state_q)
      ARB: begin
        if (pick_vld_s) begin
          state_d = WRITE;
          gnt_d   = NUM_REQ'(onehot(32'(pick_idx_s)));
          bus_d   = sel_data_s;
          busy_d  = 1'b1;
          // Winner drops to lowest priority; wraps from NUM_REQ-1 to 0.
          ptr_d   = IDX_W'((32'(pick_idx_s) + 32'd1) % 32'(NUM_REQ));
          if (32'(sel_addr_s) < 32'(NUM_REGS)) begin
            load_d = NUM_REGS'(onehot(32'(sel_addr_s)));
            err_d  = 1'b0;
          end else begin
            load_d = '0;
            err_d  = 1'b1;
          end
        end else begin
          // Idle arbitration: every output, including the bus, reads zero.
          state_d = ARB;
          bus_d   = '0;
        end
      end
      WRITE: begin
        // Strobes drop after their single valid cycle; the bus keeps its value.
        state_d = ARB;
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  // State, pointer and output registers with synchronous reset.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= ARB;
      ptr_q   <= '0;
      gnt_q   <= '0;
      load_q  <= '0;
      bus_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      load_q  <= load_d;
      bus_q   <= bus_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign GNT      = gnt_q;
  assign LOAD     = load_q;
  assign BUS_DATA = bus_q;
  assign ERR      = err_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Self-checking bench for reg_load_arbiter. Two instances share one set of
// inputs: the default one (8 registers) and one with 6 registers so that
// addresses 6 and 7 hit the out-of-range path.
module tb_reg_load_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 3;
  localparam int DW   = 16;

  logic             CLOCK = 1'b0;
  logic             RESET;
  logic [NREQ-1:0]  REQ;
  logic [AW-1:0]    addr_a [NREQ];
  logic [DW-1:0]    data_a [NREQ];
  logic [NREQ*AW-1:0] REQ_ADDR;
  logic [NREQ*DW-1:0] REQ_DATA;

  logic [NREQ-1:0] gnt8, gnt6;
  logic [7:0]      load8;
  logic [5:0]      load6;
  logic [DW-1:0]   bus8, bus6;
  logic            err8, err6, busy8, busy6;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [NREQ-1:0] e_gnt;
  logic [7:0]      e_load8;
  logic [5:0]      e_load6;
  logic            e_err8, e_err6, e_busy;
  logic [DW-1:0]   e_bus;
  int              m_ptr;
  bit              m_writing;
  int              grants [$];
  bit              reassert [NREQ];

  always #5 CLOCK = ~CLOCK;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      REQ_ADDR[i*AW +: AW] = addr_a[i];
      REQ_DATA[i*DW +: DW] = data_a[i];
    end
  end

  reg_load_arbiter #(.NUM_REQ(NREQ), .NUM_REGS(8), .ADDR_W(AW), .DATA_W(DW)) u_dut8 (
    .CLOCK(CLOCK), .RESET(RESET), .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .GNT(gnt8), .LOAD(load8), .BUS_DATA(bus8), .ERR(err8), .BUSY(busy8));

  reg_load_arbiter #(.NUM_REQ(NREQ), .NUM_REGS(6), .ADDR_W(AW), .DATA_W(DW)) u_dut6 (
    .CLOCK(CLOCK), .RESET(RESET), .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .GNT(gnt6), .LOAD(load6), .BUS_DATA(bus6), .ERR(err6), .BUSY(busy6));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Spec-level model: one call per rising edge, using the inputs seen there.
  task automatic model_step();
    int w;
    int a;
    if (RESET) begin
      e_gnt = '0; e_load8 = '0; e_load6 = '0; e_err8 = 1'b0; e_err6 = 1'b0;
      e_busy = 1'b0; e_bus = '0; m_ptr = 0; m_writing = 1'b0;
    end else if (m_writing) begin
      e_gnt = '0; e_load8 = '0; e_load6 = '0; e_err8 = 1'b0; e_err6 = 1'b0;
      e_busy = 1'b0; m_writing = 1'b0;
    end else begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (w < 0 && REQ[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      end
      if (w < 0) begin
        e_gnt = '0; e_load8 = '0; e_load6 = '0; e_err8 = 1'b0; e_err6 = 1'b0;
        e_busy = 1'b0; e_bus = '0;
      end else begin
        a = int'(addr_a[w]);
        e_gnt = '0; e_gnt[w] = 1'b1;
        e_bus = data_a[w];
        e_busy = 1'b1;
        e_load8 = '0; e_load6 = '0;
        if (a < 8) e_load8[a] = 1'b1;
        if (a < 6) e_load6[a] = 1'b1;
        e_err8 = (a >= 8);
        e_err6 = (a >= 6);
        m_ptr = (w + 1) % NREQ;
        m_writing = 1'b1;
        grants.push_back(w);
      end
    end
  endtask

  task automatic check_all();
    chk("gnt8", 32'(gnt8), 32'(e_gnt));
    chk("gnt6", 32'(gnt6), 32'(e_gnt));
    chk("load8", 32'(load8), 32'(e_load8));
    chk("load6", 32'(load6), 32'(e_load6));
    chk("err8", 32'(err8), 32'(e_err8));
    chk("err6", 32'(err6), 32'(e_err6));
    chk("bus8", 32'(bus8), 32'(e_bus));
    chk("bus6", 32'(bus6), 32'(e_bus));
    chk("busy8", 32'(busy8), 32'(e_busy));
    chk("busy6", 32'(busy6), 32'(e_busy));
    chk("gnt_onehot0", 32'($countones(gnt8) <= 1), 32'd1);
    chk("load_onehot0", 32'($countones(load8) <= 1), 32'd1);
  endtask

  task automatic tick();
    @(posedge CLOCK);
    model_step();
    @(negedge CLOCK);
    check_all();
  endtask

  initial begin
    RESET = 1'b1;
    REQ   = '0;
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i] = '0; data_a[i] = '0; reassert[i] = 1'b0;
    end

    // 1. reset then idle
    tick(); tick();
    RESET = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("idle_gnt", 32'(gnt8), 32'd0);
      chk("idle_bus", 32'(bus8), 32'd0);
    end

    // 2. single write
    REQ = 4'b0001; addr_a[0] = 3'd3; data_a[0] = 16'h64C2;
    tick();
    chk("single_gnt", 32'(gnt8), 32'h1);
    chk("single_load", 32'(load8), 32'h08);
    chk("single_bus", 32'(bus8), 32'h64C2);
    chk("single_busy", 32'(busy8), 32'd1);
    REQ = 4'b0000;
    tick();
    chk("single_after_gnt", 32'(gnt8), 32'd0);
    chk("single_after_load", 32'(load8), 32'd0);
    chk("single_after_busy", 32'(busy8), 32'd0);

    // 3. round robin with drop-on-grant, reassert one cycle later
    RESET = 1'b1; tick(); RESET = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i] = AW'(i + 1); data_a[i] = DW'(16'h1000 + i);
    end
    grants.delete();
    REQ = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (reassert[i]) begin REQ[i] = 1'b1; reassert[i] = 1'b0; end
        if (gnt8[i]) begin REQ[i] = 1'b0; reassert[i] = 1'b1; end
      end
    end
    chk("rr_count", 32'(grants.size()), 32'd5);
    if (grants.size() == 5) begin
      chk("rr_order0", 32'(grants[0]), 32'd0);
      chk("rr_order1", 32'(grants[1]), 32'd1);
      chk("rr_order2", 32'(grants[2]), 32'd2);
      chk("rr_order3", 32'(grants[3]), 32'd3);
      chk("rr_order4", 32'(grants[4]), 32'd0);
    end
    REQ = '0;
    for (int i = 0; i < NREQ; i++) reassert[i] = 1'b0;
    tick();

    // 4. pointer wrap and skip
    REQ = 4'b1000; tick();
    chk("wrap_setup_gnt", 32'(gnt8), 32'h8);
    REQ = 4'b0000; tick();
    REQ = 4'b0100; tick();
    chk("wrap_skip_gnt", 32'(gnt8), 32'h4);
    REQ = 4'b0000; tick();
    REQ = 4'b0011; tick();
    chk("wrap_to0_gnt", 32'(gnt8), 32'h1);
    REQ = 4'b0000; tick();

    // 5. out-of-range address
    addr_a[1] = 3'd7; data_a[1] = 16'h3E32;
    REQ = 4'b0010; tick();
    chk("oor_gnt6", 32'(gnt6), 32'h2);
    chk("oor_err6", 32'(err6), 32'd1);
    chk("oor_load6", 32'(load6), 32'd0);
    chk("oor_load8", 32'(load8), 32'h80);
    REQ = 4'b0000; tick();

    // 6. reset during WRITE
    addr_a[1] = 3'd5; data_a[1] = 16'h424C;
    REQ = 4'b0010; tick();
    chk("rst_mid_gnt", 32'(gnt8), 32'h2);
    chk("rst_mid_load", 32'(load8), 32'h20);
    REQ = 4'b0000; RESET = 1'b1; tick();
    chk("rst_mid_load_after", 32'(load8), 32'd0);
    chk("rst_mid_bus_after", 32'(bus8), 32'd0);
    RESET = 1'b0;
    REQ = 4'b0011; tick();
    chk("rst_mid_ptr0_gnt", 32'(gnt8), 32'h1);
    REQ = 4'b0000; tick();

    // Randomized traffic with occasional withdrawal and reset
    for (int c = 0; c < 400; c++) begin
      RESET = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (gnt8[i]) begin
          if ($urandom_range(0, 1) == 0) REQ[i] = 1'b0;
          addr_a[i] = AW'($urandom_range(0, 7));
          data_a[i] = DW'($urandom);
        end else if (!REQ[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            REQ[i] = 1'b1;
            addr_a[i] = AW'($urandom_range(0, 7));
            data_a[i] = DW'($urandom);
          end
        end else if ($urandom_range(0, 19) == 0) begin
          REQ[i] = 1'b0;
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
